div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU), radix-2 restoring.
//  Sits in the execute stage beside the ALU. Its result is one data input of the
//  writeback result-select multiplexer. busy stalls the pipeline while a divide is in flight.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be >= 2
// PORTS
//  clk     in   1      single clock; all state changes on rising edge
//  reset   in   1      synchronous, active-high reset
//  start   in   1      launch request; sampled only in IDLE
//  kill    in   1      pipeline flush; aborts any operation in flight
//  op      in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//  a       in   WIDTH  dividend (rs1), sampled with start
//  b       in   WIDTH  divisor (rs2), sampled with start
//  busy    out  1      1 while state != IDLE
//  done    out  1      one-cycle pulse: result valid
//  result  out  WIDTH  quotient or remainder per latched op; held until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0. reset beats kill and start.
//  States: IDLE, CALC, DONE.
//   IDLE: start=1 and kill=0 -> latch op, a, b, signs and |a|, |b|.
//     Special case (b==0, or signed op with a==MIN_INT and b==-1) -> DONE next cycle.
//     Otherwise -> CALC next cycle with counter=0.
//   CALC: one quotient bit per cycle, MSB first. Shift {rem,quo} left 1.
//     Trial-subtract |b| at WIDTH+1 bits; keep the difference and set the quo LSB when it is non-negative.
//     After the cycle with counter==WIDTH-1 -> DONE.
//   DONE: done=1 and result valid for exactly this cycle. Unconditionally -> IDLE.
//     result stays registered afterwards.
//  Latency: normal op accepted at cycle t -> done at t+WIDTH+1 (t+33 for WIDTH=32).
//   Special cases -> done at t+1. A start in the DONE cycle is ignored.
//   Next accept is possible the cycle after DONE.
//  start while busy: ignored; operands are not re-latched.
//  kill (state != IDLE): next state IDLE, no done pulse, result unchanged.
//   kill together with start in IDLE: start is not accepted.
//  Sign rules, signed ops (DIV/REM):
//   The division runs on magnitudes.
//   Quotient is negated iff sign(a) != sign(b) and b != 0. Remainder takes the sign of a.
//  Special results (RISC-V):
//   b==0: DIV/DIVU quotient = all ones; REM/REMU remainder = a.
//   Signed overflow (MIN_INT / -1): DIV = MIN_INT; REM = 0.
//  Width: magnitude of MIN_INT is 2^(WIDTH-1). It is representable unsigned, so there is no extra bit
//   on the operands. The remainder accumulator is WIDTH+1 bits.
//  Output sign fix-up (two's-complement negate) is applied when entering DONE.
//   result is registered; no combinational input->output path.
// STRUCTURE
//  Shared package div_pkg:
//   typedef enum logic[1:0] div_op_t {DIV, DIVU, REM, REMU}
//   typedef enum logic[1:0] div_state_t {IDLE, CALC, DONE}
//  Counter width is $clog2(WIDTH), local to the module.
//  No sub-module. The step datapath is a few lines and stays inline in one always_ff plus one always_comb.
// TESTING
//  1 DIVU a=100 b=7, start at t -> busy t+1..t+33; done at t+33 only; result=14.
//    REMU same operands -> result=2.
//  2 DIV a=-7 (0xFFFFFFF9) b=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
//    DIV a=7 b=-2 -> -3; REM a=7 b=-2 -> 1.
//  3 Divide by zero: DIV a=5 b=0 -> done at t+1, result=0xFFFFFFFF.
//    REMU a=5 b=0 -> result=5. DIVU a=0 b=0 -> 0xFFFFFFFF.
//  4 Overflow: DIV 0x80000000 / 0xFFFFFFFF -> done at t+1, result=0x80000000.
//    REM same operands -> 0. DIVU same operands -> 0 after full latency.
//  5 kill at t+10 of a DIVU 100/7 -> IDLE at t+11; no done pulse; result keeps its old value.
//    A new start at t+11 completes normally.
//  6 start asserted every cycle during a run with changing a, b -> ignored; first result unchanged.
//    reset asserted mid-CALC -> all outputs 0 the next cycle.
//    Random signed/unsigned sweep, incl. 0, 1, -1, MIN_INT, MAX_INT, checked against a reference model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and decode helpers for the RV32M iterative divider.
// Operation encodings follow funct3[1:0] of the M-extension divide group.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divide/remainder unit for DIV, DIVU, REM, REMU.
// Works on operand magnitudes; the sign fix-up is folded into the write of result.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_reg;
    logic [1:0]       op_reg;
    logic             sign_a_reg;
    logic             sign_b_reg;
    logic [WIDTH-1:0] b_abs_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] result_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             special;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             op_signed;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] calc_res;

    always_comb begin
        // Operand decode for a launch in IDLE
        in_signed = is_signed_op(op);
        a_neg     = in_signed & a[WIDTH-1];
        b_neg     = in_signed & b[WIDTH-1];
        a_abs     = a_neg ? (~a + 1'b1) : a;
        b_abs     = b_neg ? (~b + 1'b1) : b;
        special   = (b == '0) || (in_signed && (a == MIN_INT) && (b == '1));
        if (b == '0) begin
            special_res = is_rem_op(op) ? a : '1;
        end else begin
            special_res = is_rem_op(op) ? '0 : MIN_INT;
        end

        // One restoring step; the remainder never exceeds |b|-1, so WIDTH+1 bits hold the trial
        shifted = {rem_reg, quo_reg[WIDTH-1]};
        diff    = shifted - {1'b0, b_abs_reg};
        if (!diff[WIDTH]) begin
            rem_step = diff[WIDTH-1:0];
            quo_step = {quo_reg[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = shifted[WIDTH-1:0];
            quo_step = {quo_reg[WIDTH-2:0], 1'b0};
        end

        op_signed = is_signed_op(op_reg);
        q_fix     = (op_signed && (sign_a_reg != sign_b_reg)) ? (~quo_step + 1'b1) : quo_step;
        r_fix     = (op_signed && sign_a_reg) ? (~rem_step + 1'b1) : rem_step;
        calc_res  = is_rem_op(op_reg) ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            b_abs_reg  <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !kill) begin
                        op_reg     <= op;
                        sign_a_reg <= a_neg;
                        sign_b_reg <= b_neg;
                        b_abs_reg  <= b_abs;
                        quo_reg    <= a_abs;
                        rem_reg    <= '0;
                        cnt_reg    <= '0;
                        if (special) begin
                            state_reg  <= DONE;
                            result_reg <= special_res;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        state_reg <= IDLE;
                    end else begin
                        rem_reg <= rem_step;
                        quo_reg <= quo_step;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_LAST) begin
                            state_reg  <= DONE;
                            result_reg <= calc_res;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed and swept checks of div_unit: results, latency, busy/done timing, kill and reset.
module tb_div_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;
    int done_pulses = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_pulses++;
    end

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        sx = x;
        sy = y;
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            OP_DIV:  return 32'(sx / sy);
            OP_DIVU: return x / y;
            OP_REM:  return 32'(sx % sy);
            default: return x % y;
        endcase
    endfunction

    // Launches one operation and watches 40 cycles; lat is the cycle index (after the start cycle) of the first done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit hold,
                          output logic [31:0] res, output int lat, output int busy_n, output int done_n);
        res = 'x;
        lat = -1;
        busy_n = 0;
        done_n = 0;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (hold && i <= 33) begin
                start = 1'b1;
                op = 2'($urandom);
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                done_n++;
                if (lat < 0) begin
                    lat = i;
                    res = result;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("reset busy=%b done=%b result=%h", busy, done, result);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_unsigned;
        logic [1:0]  ops [2] = '{OP_DIVU, OP_REMU};
        logic [31:0] xs  [2] = '{32'd100, 32'd100};
        logic [31:0] ys  [2] = '{32'd7, 32'd7};
        logic [31:0] exps[2] = '{32'd14, 32'd2};
        logic [31:0] res;
        int lat, bn, dn;
        for (int i = 0; i < 2; i++) begin
            run_op(ops[i], xs[i], ys[i], 1'b0, res, lat, bn, dn);
            $display("unsigned op=%0d a=%h b=%h result=%h latency=%0d busy=%0d", ops[i], xs[i], ys[i], res, lat, bn);
            total++; if (res !== exps[i]) begin bad++; $display("FAIL unsigned_result[%0d] got=%h want=%h", i, res, exps[i]); end
            total++; if (lat !== 33) begin bad++; $display("FAIL unsigned_latency[%0d] got=%0d want=33", i, lat); end
            total++; if (bn !== 33) begin bad++; $display("FAIL unsigned_busy[%0d] got=%0d want=33", i, bn); end
            total++; if (dn !== 1) begin bad++; $display("FAIL unsigned_done_count[%0d] got=%0d want=1", i, dn); end
        end
    endtask

    task automatic test_signed;
        logic [1:0]  ops [6] = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REM};
        logic [31:0] xs  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] ys  [6] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] exps[6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3, 32'hFFFF_FFFF};
        logic [31:0] res;
        int lat, bn, dn;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], xs[i], ys[i], 1'b0, res, lat, bn, dn);
            $display("signed op=%0d a=%h b=%h result=%h latency=%0d", ops[i], xs[i], ys[i], res, lat);
            total++; if (res !== exps[i]) begin bad++; $display("FAIL signed_result[%0d] got=%h want=%h", i, res, exps[i]); end
            total++; if (lat !== 33) begin bad++; $display("FAIL signed_latency[%0d] got=%0d want=33", i, lat); end
            total++; if (dn !== 1) begin bad++; $display("FAIL signed_done_count[%0d] got=%0d want=1", i, dn); end
        end
    endtask

    task automatic test_div_by_zero;
        logic [1:0]  ops [4] = '{OP_DIV, OP_REMU, OP_DIVU, OP_REM};
        logic [31:0] xs  [4] = '{32'd5, 32'd5, 32'd0, 32'hFFFF_FFF9};
        logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        logic [31:0] res;
        int lat, bn, dn;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], xs[i], 32'd0, 1'b0, res, lat, bn, dn);
            $display("div_by_zero op=%0d a=%h b=0 result=%h latency=%0d busy=%0d", ops[i], xs[i], res, lat, bn);
            total++; if (res !== exps[i]) begin bad++; $display("FAIL div0_result[%0d] got=%h want=%h", i, res, exps[i]); end
            total++; if (lat !== 1) begin bad++; $display("FAIL div0_latency[%0d] got=%0d want=1", i, lat); end
            total++; if (bn !== 1) begin bad++; $display("FAIL div0_busy[%0d] got=%0d want=1", i, bn); end
            total++; if (dn !== 1) begin bad++; $display("FAIL div0_done_count[%0d] got=%0d want=1", i, dn); end
        end
    endtask

    task automatic test_overflow;
        logic [1:0]  ops [3] = '{OP_DIV, OP_REM, OP_DIVU};
        logic [31:0] exps[3] = '{32'h8000_0000, 32'd0, 32'd0};
        int          lats[3] = '{1, 1, 33};
        logic [31:0] res;
        int lat, bn, dn;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, res, lat, bn, dn);
            $display("overflow op=%0d a=80000000 b=ffffffff result=%h latency=%0d", ops[i], res, lat);
            total++; if (res !== exps[i]) begin bad++; $display("FAIL ovf_result[%0d] got=%h want=%h", i, res, exps[i]); end
            total++; if (lat !== lats[i]) begin bad++; $display("FAIL ovf_latency[%0d] got=%0d want=%0d", i, lat, lats[i]); end
            total++; if (dn !== 1) begin bad++; $display("FAIL ovf_done_count[%0d] got=%0d want=1", i, dn); end
        end
    endtask

    task automatic test_kill;
        logic [31:0] res;
        int lat, bn, dn, pulses0;
        run_op(OP_DIVU, 32'd50, 32'd5, 1'b0, res, lat, bn, dn);
        $display("kill_setup op=1 a=00000032 b=00000005 result=%h", res);
        total++; if (res !== 32'd10) begin bad++; $display("FAIL kill_setup_result got=%h want=0000000a", res); end
        pulses0 = done_pulses;
        @(posedge clk); #1;
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; start = 1'b1; op = OP_DIVU; a = 32'd200; b = 32'd9;
        @(negedge clk);
        $display("kill op=1 a=00000064 b=00000007 busy_after=%b result=%h", busy, result);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_idle busy got=%b want=0", busy); end
        total++; if (result !== 32'd10) begin bad++; $display("FAIL kill_result_held got=%h want=0000000a", result); end
        total++; if (done_pulses !== pulses0) begin bad++; $display("FAIL kill_no_done pulses got=%0d want=%0d", done_pulses, pulses0); end
        lat = -1;
        res = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (done === 1'b1 && lat < 0) begin
                lat = i;
                res = result;
            end
        end
        $display("restart op=1 a=000000c8 b=00000009 result=%h latency=%0d", res, lat);
        total++; if (res !== 32'd22) begin bad++; $display("FAIL restart_result got=%h want=00000016", res); end
        total++; if (lat !== 33) begin bad++; $display("FAIL restart_latency got=%0d want=33", lat); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res;
        int lat, bn, dn;
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b1, res, lat, bn, dn);
        $display("held_start op=1 a=00000064 b=00000007 result=%h latency=%0d busy=%0d", res, lat, bn);
        total++; if (res !== 32'd14) begin bad++; $display("FAIL held_result got=%h want=0000000e", res); end
        total++; if (lat !== 33) begin bad++; $display("FAIL held_latency got=%0d want=33", lat); end
        total++; if (bn !== 33) begin bad++; $display("FAIL held_busy got=%0d want=33", bn); end
        total++; if (dn !== 1) begin bad++; $display("FAIL held_done_count got=%0d want=1", dn); end
        @(negedge clk);
        total++; if (result !== 32'd14) begin bad++; $display("FAIL held_result_kept got=%h want=0000000e", result); end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        $display("reset_mid busy=%b done=%b result=%h", busy, done, result);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_mid_done got=%b want=0", done); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_mid_result got=%h want=0", result); end
    endtask

    task automatic test_sweep;
        logic [31:0] vals[6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
        logic [31:0] x, y, exp_res, res;
        logic [1:0]  o;
        int lat, bn, dn, exp_lat;
        for (int n = 0; n < 160; n++) begin
            if (n < 144) begin
                o = 2'(n % 4);
                x = vals[(n / 4) % 6];
                y = vals[n / 24];
            end else begin
                o = 2'($urandom);
                x = $urandom;
                y = (n % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            end
            exp_res = ref_div(o, x, y);
            exp_lat = (y == 32'd0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 1 : 33;
            run_op(o, x, y, 1'b0, res, lat, bn, dn);
            $display("sweep op=%0d a=%h b=%h result=%h expected=%h latency=%0d", o, x, y, res, exp_res, lat);
            total++; if (res !== exp_res) begin bad++; $display("FAIL sweep_result[%0d] got=%h want=%h", n, res, exp_res); end
            total++; if (lat !== exp_lat) begin bad++; $display("FAIL sweep_latency[%0d] got=%0d want=%0d", n, lat, exp_lat); end
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_div_by_zero;
        test_overflow;
        test_kill;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

endmodule
